grid_ram_scheduler: RTL and testbench

// Owns the single port of the snake grid status RAM (2-bit cell status, address {x,y}) and shares it

---
 rtl/grid_ram_scheduler.sv | 168 ++++++++++++++++
 tb/tb_grid_ram_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_ram_scheduler.sv
// Arbitrates the single grid-status RAM port between game-logic accesses (always win)
// and a raster scanner that repaints every cell to the VGA adapter once per frame_tick.
module grid_ram_scheduler #(
    parameter int       X_MAX   = 159,
    parameter int       Y_MAX   = 119,
    parameter logic [2:0] C_EMPTY = 3'b000,
    parameter logic [2:0] C_SNAKE = 3'b010,
    parameter logic [2:0] C_FOOD  = 3'b100,
    parameter logic [2:0] C_WALL  = 3'b111
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_tick,
    input  logic        game_req,
    input  logic        game_we,
    input  logic [7:0]  game_x,
    input  logic [6:0]  game_y,
    input  logic [1:0]  game_wdata,
    output logic        game_ack,
    output logic [1:0]  game_rdata,
    output logic [14:0] ram_addr,
    output logic [1:0]  ram_wdata,
    output logic        ram_wren,
    input  logic [1:0]  ram_rdata,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot,
    output logic        sweep_busy,
    output logic        sweep_done,
    output logic        frame_overrun
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [7:0] X_LAST = 8'(X_MAX);
    localparam logic [6:0] Y_LAST = 7'(Y_MAX);

    logic [1:0] r_state;
    logic [7:0] r_x;
    logic [6:0] r_y;
    logic       r_game_busy;
    logic       r_game_we;
    logic [7:0] r_tag_x;
    logic [6:0] r_tag_y;
    logic       r_tag_v;
    logic [7:0] r_vga_x;
    logic [6:0] r_vga_y;
    logic [2:0] r_vga_colour;
    logic       r_vga_plot;
    logic       r_sweep_done;
    logic       r_overrun;

    logic       w_grant;
    logic       w_scan;
    logic       w_last;
    logic       w_busy;
    logic [2:0] w_colour;

    // r_game_busy marks the ack cycle, so a request held through its ack is not regranted.
    assign w_grant = reset_n & game_req & ~r_game_busy;
    assign w_scan  = (r_state == S_SWEEP) & ~w_grant;
    assign w_last  = (r_x == X_LAST) && (r_y == Y_LAST);
    assign w_busy  = (r_state != S_IDLE);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        ram_addr  = {r_x, r_y};
        ram_wren  = 1'b0;
        ram_wdata = 2'b00;
        if (w_grant) begin
            ram_addr  = {game_x, game_y};
            ram_wren  = game_we;
            ram_wdata = game_wdata;
        end
    end

    always_comb begin
        w_colour = C_EMPTY;
        case (ram_rdata)
            2'd1:    w_colour = C_SNAKE;
            2'd2:    w_colour = C_FOOD;
            2'd3:    w_colour = C_WALL;
            default: w_colour = C_EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_game_busy <= 1'b0;
            r_game_we   <= 1'b0;
        end else begin
            r_game_busy <= w_grant;
            if (w_grant) r_game_we <= game_we;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (frame_tick) r_state <= S_SWEEP;
                S_SWEEP: begin
                    if (w_scan) begin
                        if (w_last) begin
                            r_state <= S_DRAIN;
                            r_x     <= '0;
                            r_y     <= '0;
                        end else if (r_x == X_LAST) begin
                            r_x <= '0;
                            r_y <= r_y + 7'd1;
                        end else begin
                            r_x <= r_x + 8'd1;
                        end
                    end
                end
                // Once the tag stage is empty, the only plot left is the last cell.
                S_DRAIN: if (r_vga_plot && !r_tag_v) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tag_x      <= '0;
            r_tag_y      <= '0;
            r_tag_v      <= 1'b0;
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_colour <= '0;
            r_vga_plot   <= 1'b0;
            r_sweep_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_tag_v <= w_scan;
            if (w_scan) begin
                r_tag_x <= r_x;
                r_tag_y <= r_y;
            end
            r_vga_plot <= r_tag_v;
            if (r_tag_v) begin
                r_vga_x      <= r_tag_x;
                r_vga_y      <= r_tag_y;
                r_vga_colour <= w_colour;
            end
            r_sweep_done <= (r_state == S_DRAIN) && r_vga_plot && !r_tag_v;
            if (frame_tick && w_busy) r_overrun <= 1'b1;
        end
    end

    assign game_ack      = r_game_busy;
    assign game_rdata    = (r_game_busy && !r_game_we) ? ram_rdata : 2'b00;
    assign vga_x         = r_vga_x;
    assign vga_y         = r_vga_y;
    assign vga_colour    = r_vga_colour;
    assign vga_plot      = r_vga_plot;
    assign sweep_busy    = w_busy;
    assign sweep_done    = r_sweep_done;
    assign frame_overrun = r_overrun;

endmodule

// File: tb/tb_grid_ram_scheduler.sv
// Directed bench for grid_ram_scheduler: behavioural grid RAM, raster-order plot monitor,
// hand-computed expectations for game access timing, sweeps, contention, overrun and reset.
module tb_grid_ram_scheduler;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        game_req = 1'b0;
    logic        game_we = 1'b0;
    logic [7:0]  game_x = '0;
    logic [6:0]  game_y = '0;
    logic [1:0]  game_wdata = '0;
    logic        game_ack;
    logic [1:0]  game_rdata;
    logic [14:0] ram_addr;
    logic [1:0]  ram_wdata;
    logic        ram_wren;
    logic [1:0]  ram_rdata = '0;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        sweep_busy;
    logic        sweep_done;
    logic        frame_overrun;

    grid_ram_scheduler dut (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
        .game_req(game_req), .game_we(game_we), .game_x(game_x), .game_y(game_y),
        .game_wdata(game_wdata), .game_ack(game_ack), .game_rdata(game_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_rdata(ram_rdata),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .sweep_busy(sweep_busy), .sweep_done(sweep_done), .frame_overrun(frame_overrun)
    );

    always #5 clk = ~clk;

    // Single-port RAM with one cycle of read latency (old data on read-during-write).
    logic [1:0] mem [0:32767];
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    logic [1:0] exp_stat [0:159][0:119];

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] col_of(input logic [1:0] s);
        case (s)
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            2'd3:    return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Plot / ack monitor, sampled on the falling edge.
    bit         mon_clr = 1'b0;
    bit         ack_chk = 1'b0;
    int         cyc = 0, plots = 0, order_err = 0, busy_cnt = 0, done_seen = 0;
    int         tick_cyc = 0, first_plot_cyc = 0, last_plot_cyc = 0, done_cyc = 0;
    int         ack_cnt = 0, ack_err = 0, last_ack_cyc = 0;
    logic [7:0] mx = '0;
    logic [6:0] my = '0;
    logic [2:0] first_col = '0;

    always @(negedge clk) begin
        cyc++;
        if (mon_clr) begin
            plots = 0; order_err = 0; busy_cnt = 0; done_seen = 0;
            ack_cnt = 0; ack_err = 0; last_ack_cyc = 0;
            mx = '0; my = '0;
        end else begin
            if (sweep_busy) busy_cnt++;
            if (frame_tick && !sweep_busy) tick_cyc = cyc;
            if (vga_plot) begin
                if (plots == 0) begin
                    first_plot_cyc = cyc;
                    first_col = vga_colour;
                end
                if (plots >= 19200) order_err++;
                else if (vga_x !== mx || vga_y !== my || vga_colour !== col_of(exp_stat[mx][my]))
                    order_err++;
                plots++;
                last_plot_cyc = cyc;
                if (mx == 8'd159) begin
                    mx = '0;
                    my = my + 7'd1;
                end else begin
                    mx = mx + 8'd1;
                end
            end
            if (sweep_done) begin
                done_seen++;
                done_cyc = cyc;
            end
            if (game_ack) begin
                if (ack_chk && last_ack_cyc != 0 && cyc - last_ack_cyc != 2) ack_err++;
                if (ack_chk && game_rdata !== 2'd2) ack_err++;
                last_ack_cyc = cyc;
                ack_cnt++;
            end
        end
    end

    task automatic clear_monitor;
        mon_clr = 1'b1;
        step;
        mon_clr = 1'b0;
    endtask

    // Runs one full sweep; ovr_at / wr_at are sweep-relative cycles (0 = unused).
    task automatic run_sweep(input int exp_busy, input int ovr_at, input int wr_at,
                             input bit contend, input logic [2:0] exp_first);
        int k;
        clear_monitor();
        if (contend) begin
            game_req = 1'b1; game_we = 1'b0; game_x = 8'd5; game_y = 7'd7;
            ack_chk = 1'b1;
        end
        frame_tick = 1'b1;
        step;
        frame_tick = 1'b0;
        k = 1;
        while (done_seen == 0 && k < 50000) begin
            if (ovr_at != 0 && k == ovr_at) frame_tick = 1'b1;
            if (ovr_at != 0 && k == ovr_at + 1) frame_tick = 1'b0;
            if (wr_at != 0 && k == wr_at) begin
                game_req = 1'b1; game_we = 1'b1; game_x = 8'd0; game_y = 7'd0; game_wdata = 2'd2;
            end
            if (wr_at != 0 && k == wr_at + 2) begin
                game_req = 1'b0; game_we = 1'b0;
            end
            step;
            k++;
        end
        ack_chk = 1'b0;
        game_req = 1'b0;
        game_we = 1'b0;
        check("sweep_done_seen", done_seen, 1);
        check("plot_count", plots, 19200);
        check("plot_order_errs", order_err, 0);
        check("busy_cycles", busy_cnt, exp_busy);
        check("first_plot_latency", first_plot_cyc - tick_cyc, 3);
        check("first_plot_colour", first_col, exp_first);
        check("done_after_last_plot", done_cyc - last_plot_cyc, 1);
        check("last_plot_held", {vga_x, vga_y, vga_colour}, {8'd159, 7'd119, 3'b010});
    endtask

    initial begin
        for (int a = 0; a < 32768; a++) mem[a] = 2'd0;
        for (int x = 0; x < 160; x++)
            for (int y = 0; y < 120; y++) exp_stat[x][y] = 2'd0;
        mem[{8'd0, 7'd0}]     = 2'd3;
        mem[{8'd159, 7'd119}] = 2'd1;
        exp_stat[0][0]     = 2'd3;
        exp_stat[159][119] = 2'd1;

        // Reset state
        repeat (3) step;
        @(negedge clk);
        check("rst_game_ram", {game_ack, game_rdata, ram_addr, ram_wdata, ram_wren}, 0);
        check("rst_vga_status", {vga_x, vga_y, vga_colour, vga_plot, sweep_busy, sweep_done, frame_overrun}, 0);
        reset_n = 1'b1;
        step;

        // Idle write then read of (5,7)
        game_req = 1'b1; game_we = 1'b1; game_x = 8'd5; game_y = 7'd7; game_wdata = 2'd2;
        @(negedge clk);
        check("wr_grant_wren", ram_wren, 1);
        check("wr_grant_addr", ram_addr, {8'd5, 7'd7});
        check("wr_grant_wdata", ram_wdata, 2);
        check("wr_grant_no_ack", game_ack, 0);
        step;
        @(negedge clk);
        check("wr_ack", game_ack, 1);
        check("wr_ack_no_regrant", ram_wren, 0);
        step;
        game_req = 1'b0; game_we = 1'b0;
        exp_stat[5][7] = 2'd2;
        @(negedge clk);
        check("wr_ack_single", game_ack, 0);
        step;
        game_req = 1'b1;
        @(negedge clk);
        check("rd_grant_wren", ram_wren, 0);
        check("rd_grant_addr", ram_addr, {8'd5, 7'd7});
        step;
        @(negedge clk);
        check("rd_ack", game_ack, 1);
        check("rd_data", game_rdata, 2);
        step;
        game_req = 1'b0;
        step;

        // Clean sweep
        run_sweep(19202, 0, 0, 1'b0, 3'b111);
        check("no_overrun_yet", frame_overrun, 0);

        // Reset in the middle of a sweep
        clear_monitor();
        frame_tick = 1'b1;
        step;
        frame_tick = 1'b0;
        repeat (50) step;
        #2 reset_n = 1'b0;
        #1;
        check("midrst_game_ram", {game_ack, game_rdata, ram_addr, ram_wdata, ram_wren}, 0);
        check("midrst_vga_status", {vga_x, vga_y, vga_colour, vga_plot, sweep_busy, sweep_done, frame_overrun}, 0);
        repeat (3) step;
        reset_n = 1'b1;
        repeat (3) step;
        check("midrst_no_done", done_seen, 0);
        check("midrst_idle", sweep_busy, 0);

        // Overrun at cycle 100 plus a write-behind to (0,0) after it was plotted
        run_sweep(19203, 100, 10, 1'b0, 3'b111);
        check("wb_write_acked", ack_cnt, 1);
        check("overrun_set", frame_overrun, 1);
        exp_stat[0][0] = 2'd2;
        repeat (5) step;
        @(negedge clk);
        check("overrun_no_restart", sweep_busy, 0);
        check("overrun_sticky", frame_overrun, 1);
        step;

        // Contended sweep: game_req held high throughout; also shows the new (0,0) colour
        run_sweep(38401, 0, 0, 1'b1, 3'b100);
        check("contend_ack_errs", ack_err, 0);
        check("contend_ack_count", (ack_cnt >= 19200) ? 1 : 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
